wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 111 +++++++++++
 tb/tb_wb_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage with data-memory handshake and retirement tracking
module wb_stage (
    input  logic        clk,
    input  logic        rstd,
    input  logic [31:0] pc_in,
    input  logic [5:0]  op_in,
    input  logic [31:0] os_in,
    input  logic [31:0] ot_in,
    input  logic [31:0] imm_dpl_in,
    input  logic [4:0]  wreg_in,
    input  logic [31:0] result_in,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] retire_pc,
    output logic [31:0] retire_cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [5:0] OP_LW  = 6'd16;
    localparam logic [5:0] OP_SW  = 6'd24;
    localparam logic [5:0] OP_NOP = 6'd55;

    logic [0:0]  state;
    logic        is_lw;
    logic        is_sw;
    logic        is_mem;
    logic        is_nop;
    logic        in_busy;
    logic        start_mem;
    logic        retire;
    logic        writes_reg;
    logic [31:0] wb_data;

    // Decode the held instruction and decide what happens at the coming edge
    always_comb begin
        is_lw      = (op_in == OP_LW);
        is_sw      = (op_in == OP_SW);
        is_mem     = is_lw | is_sw;
        is_nop     = (op_in == OP_NOP);
        in_busy    = (state == ST_BUSY);
        start_mem  = !in_busy && is_mem;
        // A memory op retires on its ack; anything else retires straight from IDLE
        retire     = in_busy ? mem_ack : (!is_mem && !is_nop);
        // Stores never write the register file; register 0 is never written
        writes_reg = !is_sw && (wreg_in != 5'd0);
        wb_data    = is_lw ? mem_rdata : result_in;
        stall      = in_busy ? !mem_ack : is_mem;
        mem_req    = in_busy;
    end

    // Two-state request FSM: enter BUSY on a memory op, leave on ack
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state <= ST_IDLE;
        end else if (start_mem) begin
            state <= ST_BUSY;
        end else if (in_busy && mem_ack) begin
            state <= ST_IDLE;
        end
    end

    // Memory request payload is latched once on entry and held through BUSY
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_we    <= 1'b0;
        end else if (start_mem) begin
            mem_addr  <= os_in + imm_dpl_in;
            mem_wdata <= ot_in;
            mem_we    <= is_sw;
        end
    end

    // Register-file write strobe is a single-cycle pulse; address/data hold otherwise
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
        end else begin
            rf_we <= retire && writes_reg;
            if (retire && writes_reg) begin
                rf_waddr <= wreg_in;
                rf_wdata <= wb_data;
            end
        end
    end

    // Retirement bookkeeping: last retired PC and a wrapping retirement counter
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            retire_pc  <= 32'd0;
            retire_cnt <= 32'd0;
        end else if (retire) begin
            retire_pc  <= pc_in;
            retire_cnt <= retire_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage
module tb_wb_stage;

    logic        clk;
    logic        rstd;
    logic [31:0] pc_in;
    logic [5:0]  op_in;
    logic [31:0] os_in;
    logic [31:0] ot_in;
    logic [31:0] imm_dpl_in;
    logic [4:0]  wreg_in;
    logic [31:0] result_in;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] retire_pc;
    logic [31:0] retire_cnt;

    wb_stage dut (
        .clk        (clk),
        .rstd       (rstd),
        .pc_in      (pc_in),
        .op_in      (op_in),
        .os_in      (os_in),
        .ot_in      (ot_in),
        .imm_dpl_in (imm_dpl_in),
        .wreg_in    (wreg_in),
        .result_in  (result_in),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .retire_pc  (retire_pc),
        .retire_cnt (retire_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic check_en = 1'b0;

    // Transaction-level model: one outstanding memory op at most, plus last retirement
    logic        m_inflight = 1'b0;
    logic [31:0] m_addr     = '0;
    logic [31:0] m_wdata    = '0;
    logic        m_we       = 1'b0;
    logic        m_rf_we    = 1'b0;
    logic [4:0]  m_waddr    = '0;
    logic [31:0] m_rf_data  = '0;
    logic [31:0] m_pc       = '0;
    logic [31:0] m_cnt      = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic op_is_mem(input logic [5:0] op);
        return (op == 6'd16) || (op == 6'd24);
    endfunction

    task automatic model_retire();
        m_cnt = m_cnt + 32'd1;
        m_pc  = pc_in;
        if (op_in != 6'd24 && wreg_in != 5'd0) begin
            m_rf_we   = 1'b1;
            m_waddr   = wreg_in;
            m_rf_data = (op_in == 6'd16) ? mem_rdata : result_in;
        end
    endtask

    // Advance the model on each edge using the instruction-level rules
    always @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            m_inflight = 1'b0; m_addr = '0; m_wdata = '0; m_we = 1'b0;
            m_rf_we = 1'b0; m_waddr = '0; m_rf_data = '0; m_pc = '0; m_cnt = '0;
        end else begin
            m_rf_we = 1'b0;
            if (m_inflight) begin
                if (mem_ack) begin
                    m_inflight = 1'b0;
                    model_retire();
                end
            end else if (op_is_mem(op_in)) begin
                m_inflight = 1'b1;
                m_addr     = os_in + imm_dpl_in;
                m_wdata    = ot_in;
                m_we       = (op_in == 6'd24);
            end else if (op_in != 6'd55) begin
                model_retire();
            end
        end
    end

    // Compare every output against the model mid-cycle
    always @(negedge clk) begin
        if (check_en) begin
            chk("stall", stall, op_is_mem(op_in) && !(m_inflight && mem_ack));
            chk("mem_req", mem_req, m_inflight);
            if (m_inflight) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_wdata", mem_wdata, m_wdata);
                chk("mem_we", mem_we, m_we);
            end
            chk("rf_we", rf_we, m_rf_we);
            chk("rf_waddr", rf_waddr, m_waddr);
            chk("rf_wdata", rf_wdata, m_rf_data);
            chk("retire_pc", retire_pc, m_pc);
            chk("retire_cnt", retire_cnt, m_cnt);
        end
    end

    // Present one instruction, hold it while stalled, ack memory after ack_after BUSY cycles
    task automatic do_op(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] os,
                         input logic [31:0] ot, input logic [31:0] imm, input logic [4:0] wreg,
                         input logic [31:0] res, input int ack_after, input logic [31:0] rdata,
                         output int stalls, output logic [31:0] seen_addr, output logic seen_we,
                         output logic [31:0] seen_wdata);
        int  cyc;
        logic done;
        op_in = op; pc_in = pc; os_in = os; ot_in = ot; imm_dpl_in = imm;
        wreg_in = wreg; result_in = res; mem_rdata = rdata; mem_ack = 1'b0;
        stalls = 0; cyc = 0; done = 1'b0;
        seen_addr = '0; seen_we = 1'b0; seen_wdata = '0;
        for (int g = 0; g < 40 && !done; g++) begin
            if (mem_req) begin
                cyc++;
                if (cyc == 1) begin
                    seen_addr = mem_addr; seen_we = mem_we; seen_wdata = mem_wdata;
                end
                mem_ack = (cyc >= ack_after);
            end else begin
                mem_ack = 1'b0;
            end
            #1;
            if (!stall) done = 1'b1;
            else stalls++;
            @(posedge clk); #1;
        end
        if (!done) chk("op_timeout", 32'd0, 32'd1);
        mem_ack = 1'b0;
        op_in   = 6'd55;
    endtask

    int          st;
    logic [31:0] sa;
    logic        swe;
    logic [31:0] swd;

    initial begin
        rstd = 1'b1; op_in = 6'd55; pc_in = '0; os_in = '0; ot_in = '0; imm_dpl_in = '0;
        wreg_in = '0; result_in = '0; mem_ack = 1'b0; mem_rdata = '0;
        #2 rstd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_retire_cnt", retire_cnt, 32'd0);
        check_en = 1'b1;
        @(negedge clk); #1 rstd = 1'b1;
        @(posedge clk); #1;
        chk("nop_after_rst_we", rf_we, 1'b0);
        chk("nop_after_rst_cnt", retire_cnt, 32'd0);

        // ALU op to r5
        do_op(6'd3, 32'h100, 0, 0, 0, 5'd5, 32'hDEADBEEF, 1, 0, st, sa, swe, swd);
        chk("alu_stalls", st, 0);
        chk("alu_rf_we", rf_we, 1'b1);
        chk("alu_waddr", rf_waddr, 5'd5);
        chk("alu_wdata", rf_wdata, 32'hDEADBEEF);
        chk("alu_cnt", retire_cnt, 32'd1);
        chk("alu_pc", retire_pc, 32'h100);

        // LW with ack on third BUSY cycle
        do_op(6'd16, 32'h104, 32'h1000, 0, 32'h10, 5'd3, 32'h0, 3, 32'h12345678, st, sa, swe, swd);
        chk("lw_addr", sa, 32'h1010);
        chk("lw_we", swe, 1'b0);
        chk("lw_stalls", st, 3);
        chk("lw_rf_we", rf_we, 1'b1);
        chk("lw_waddr", rf_waddr, 5'd3);
        chk("lw_wdata", rf_wdata, 32'h12345678);
        chk("lw_cnt", retire_cnt, 32'd2);

        // SW with wrapping address, ack in the first BUSY cycle
        do_op(6'd24, 32'h108, 32'hFFFFFFFC, 32'hA5A5A5A5, 32'h8, 5'd7, 0, 1, 0, st, sa, swe, swd);
        chk("sw_addr", sa, 32'h4);
        chk("sw_we", swe, 1'b1);
        chk("sw_wdata", swd, 32'hA5A5A5A5);
        chk("sw_rf_we", rf_we, 1'b0);
        chk("sw_hold_wdata", rf_wdata, 32'h12345678);
        chk("sw_cnt", retire_cnt, 32'd3);
        chk("sw_pc", retire_pc, 32'h108);

        // NOP stream, then ALU op to r0
        repeat (3) @(posedge clk);
        #1;
        do_op(6'd1, 32'h10C, 0, 0, 0, 5'd0, 32'h55AA, 1, 0, st, sa, swe, swd);
        chk("r0_rf_we", rf_we, 1'b0);
        chk("r0_cnt", retire_cnt, 32'd4);
        chk("r0_hold_waddr", rf_waddr, 5'd3);

        // Back-to-back memory ops: one stall cycle each
        do_op(6'd16, 32'h110, 32'h20, 0, 32'h4, 5'd9, 0, 1, 32'hCAFEF00D, st, sa, swe, swd);
        chk("b2b_lw_stalls", st, 1);
        chk("b2b_lw_wdata", rf_wdata, 32'hCAFEF00D);
        do_op(6'd24, 32'h114, 32'h30, 32'h77, 32'h0, 5'd2, 0, 1, 0, st, sa, swe, swd);
        chk("b2b_sw_stalls", st, 1);
        chk("b2b_sw_addr", sa, 32'h30);
        chk("b2b_cnt", retire_cnt, 32'd6);

        // Reset asserted in BUSY before ack
        op_in = 6'd16; pc_in = 32'h200; os_in = 32'h40; imm_dpl_in = 32'h0; wreg_in = 5'd4;
        @(posedge clk); #1;
        chk("rb_mem_req_busy", mem_req, 1'b1);
        #1 rstd = 1'b0;
        #1;
        chk("rb_mem_req", mem_req, 1'b0);
        chk("rb_mem_addr", mem_addr, 32'd0);
        chk("rb_rf_we", rf_we, 1'b0);
        chk("rb_cnt", retire_cnt, 32'd0);
        chk("rb_pc", retire_pc, 32'd0);
        op_in = 6'd55;
        @(negedge clk); #1 rstd = 1'b1;
        @(posedge clk); #1 mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        @(posedge clk); #1 mem_ack = 1'b0;
        chk("late_ack_rf_we", rf_we, 1'b0);
        chk("late_ack_cnt", retire_cnt, 32'd0);
        chk("late_ack_wdata", rf_wdata, 32'd0);

        // Counter wrap from a preloaded value
        dut.retire_cnt = 32'hFFFFFFFE;
        m_cnt          = 32'hFFFFFFFE;
        do_op(6'd2, 32'h300, 0, 0, 0, 5'd1, 32'h1, 1, 0, st, sa, swe, swd);
        chk("wrap_ff", retire_cnt, 32'hFFFFFFFF);
        do_op(6'd2, 32'h304, 0, 0, 0, 5'd1, 32'h2, 1, 0, st, sa, swe, swd);
        chk("wrap_zero", retire_cnt, 32'd0);
        chk("wrap_pc", retire_pc, 32'h304);

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
